wb_stream_port: RTL
===================

Name: wb_stream_port

Overview:
- Wishbone slave sitting directly downstream of the user-area Wishbone decoder; it occupies one decoder slave slot.
- Converts CPU word writes into an AXI-Stream master stream feeding the FIR/accelerator, through a TX FIFO.
- Collects the accelerator's AXI-Stream output into an RX FIFO for CPU reads.
- Exposes status, control and sticky error flags.

Parameters:
- DEPTH, 8, entries per FIFO; must be a power of 2, at least 2.
- DW, 32, data width of the Wishbone data bus and both streams.

Ports:
- wbs_clk_i  in  1  single clock for the whole block.
- wbs_rst_i  in  1  reset; asynchronous, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe; the decoder has already qualified this slot.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  address; only bits [4:2] are decoded.
- wbs_dat_i  in  DW  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  DW  read data.
- m_axis_tvalid  out  1  TX stream valid.
- m_axis_tready  in  1  TX stream ready.
- m_axis_tdata  out  DW  TX stream data.
- m_axis_tlast  out  1  TX stream last.
- s_axis_tvalid  in  1  RX stream valid.
- s_axis_tready  out  1  RX stream ready.
- s_axis_tdata  in  DW  RX stream data.
- s_axis_tlast  in  1  RX stream last.

Behaviour:
- Register map (offset = adr[4:2]):
  - 0x00 TX_DATA: write-only; a write pushes wbs_dat_i. wbs_sel_i is ignored here.
  - 0x04 RX_DATA: read-only; a read pops the head entry.
  - 0x08 STATUS: read-only.
    - [7:0] tx_count, [15:8] rx_count
    - [16] tx_full, [17] tx_empty, [18] rx_full, [19] rx_empty
    - [20] ovf, [21] udf, [22] rx_last_seen
  - 0x0C CTRL: write-only, self-clearing, honoured only when wbs_sel_i[0]=1.
    - [0] flush TX, [1] flush RX, [2] clear sticky flags.
  - Any other offset: acknowledged, reads 0, writes have no effect.
- Wishbone FSM with two states, IDLE and ACK:
  - IDLE to ACK when cyc&stb=1.
  - ACK to IDLE unconditionally.
  - wbs_ack_o=1 exactly in ACK, so latency is one cycle and ack never lasts 2 cycles.
  - A held strobe gets its next ack 2 cycles later.
  - Side effects (push, pop, CTRL action) and the wbs_dat_o register load happen on the IDLE-to-ACK edge, once per transfer.
  - wbs_dat_o is 0 whenever ack=0.
- TX FIFO:
  - A push is accepted only if tx_count<DEPTH at the start of the cycle. Otherwise the word is dropped, ovf is set (sticky), and ack still occurs.
  - m_axis_tvalid = !tx_empty; m_axis_tdata = head entry.
  - A pop happens on tvalid&tready; tdata stays stable while tvalid=1 and tready=0.
- RX FIFO:
  - s_axis_tready = !rx_full; a beat is pushed on tvalid&tready.
  - tlast=1 on an accepted beat sets rx_last_seen (sticky).
  - Reading RX_DATA while empty returns 0, sets udf (sticky), and pops nothing.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged.
  - Push on a full FIFO is still rejected, even if a pop happens in the same cycle.
  - Pop and push on an empty FIFO in the same cycle: the pop is invalid, so only the push occurs.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits, zero-extended into their 8-bit STATUS fields.
- Flush and clear act on the ACK edge and override any push or pop on that FIFO in the same cycle.
- Reset (asynchronous, any time, including mid-transfer):
  - FSM returns to IDLE; all pointers, counts and sticky flags go to 0.
  - Output reset values: wbs_ack_o=0, wbs_dat_o=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0.
  - s_axis_tready becomes 1 on the first clock after reset deassertion.
  - FIFO storage contents are don't-care.

Optional Feature:
- Macro STREAM_TLAST_EN adds register 0x10 LEN (read/write, [15:0]) and a beat counter.
  - m_axis_tlast=1 on the TX beat where counter==LEN-1; the counter resets to 0 on that beat.
  - LEN=0 means tlast is never asserted.
  - Flushing TX also zeroes the counter.
- Without the macro: m_axis_tlast is tied to 0, and offset 0x10 behaves as unmapped.

Test Plan:
- Reset, then read STATUS: returns 0x000A0000 (tx_empty=1, rx_empty=1); s_axis_tready=1.
- Write 0x11, 0x22, 0x33 to TX_DATA with m_axis_tready=0; hold 4 cycles:
  - tdata stays 0x11 and tx_count=3.
  - Then tready=1: beats 0x11, 0x22, 0x33 come out in order and tvalid drops.
- With tready=0, write DEPTH+1 words: the last write is acked but dropped; STATUS reports tx_full=1 and ovf=1.
  - Write CTRL=0x5: tx_count=0 and ovf=0.
- Drive 3 RX beats 0xA, 0xB, 0xC with tlast on 0xC:
  - Four RX_DATA reads return 0xA, 0xB, 0xC, then 0 with udf=1.
  - rx_last_seen=1.
- Hold stb for 6 cycles: exactly 3 single-cycle acks are seen.
  - Assert reset in the ACK cycle: ack drops immediately and the FIFOs empty.
- With STREAM_TLAST_EN, LEN=4 and 8 words sent: tlast is high on beats 4 and 8 only.

Source files
------------

// File: rtl/wb_stream_port_if.sv
// Bus bundle for wb_stream_port: the Wishbone slave slot plus the TX and RX AXI-Stream links.
// "slave" is the port side, "master" is the CPU/decoder + accelerator side.
interface wb_stream_port_if #(
   parameter int unsigned DW = 32
) ();
   logic          wbs_cyc_i;
   logic          wbs_stb_i;
   logic          wbs_we_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_adr_i;
   logic [DW-1:0] wbs_dat_i;
   logic          wbs_ack_o;
   logic [DW-1:0] wbs_dat_o;

   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;

   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tlast;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
      input  m_axis_tready,
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
      output s_axis_tready
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
      output m_axis_tready,
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
      input  s_axis_tready
   );
endinterface

// File: rtl/wb_stream_port.sv
// Wishbone slave bridging CPU word writes/reads to a TX and an RX AXI-Stream FIFO.
// Optional macro STREAM_TLAST_EN adds the LEN register (0x10) and TX tlast generation.
module wb_stream_port #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 32
) (
   input logic              wbs_clk_i,
   input logic              wbs_rst_i,
   wb_stream_port_if.slave  bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [0:0] {StIdle, StAck} state_e;

   state_e state_q, state_d;

   logic          xfer;
   logic [2:0]    offset;
   logic          wr_tx, rd_rx, wr_ctrl;
   logic          flush_tx, flush_rx, clr_flags;

   logic [DW-1:0] tx_mem [DEPTH];
   logic [AW-1:0] tx_wptr_q, tx_rptr_q;
   logic [CW-1:0] tx_cnt_q;
   logic          tx_full, tx_empty, tx_push, tx_pop;

   logic [DW-1:0] rx_mem [DEPTH];
   logic [AW-1:0] rx_wptr_q, rx_rptr_q;
   logic [CW-1:0] rx_cnt_q;
   logic          rx_full, rx_empty, rx_push, rx_pop;

   logic          ovf_q, udf_q, last_seen_q;
   logic          rdy_q;
   logic [31:0]   status;
   logic [DW-1:0] rdata, dat_q;
   logic          tlast;

   logic unused_bus;
   assign unused_bus = ^{bus.wbs_adr_i[31:5], bus.wbs_adr_i[1:0], bus.wbs_sel_i[3:1]};

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
      if (!wbs_rst_i) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.wbs_cyc_i && bus.wbs_stb_i) state_d = StAck;
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // All side effects key off the IDLE->ACK edge, so a held strobe acts once per ack.
   assign xfer      = (state_q == StIdle) && bus.wbs_cyc_i && bus.wbs_stb_i;
   assign offset    = bus.wbs_adr_i[4:2];
   assign wr_tx     = xfer && bus.wbs_we_i && (offset == 3'd0);
   assign rd_rx     = xfer && !bus.wbs_we_i && (offset == 3'd1);
   assign wr_ctrl   = xfer && bus.wbs_we_i && (offset == 3'd3) && bus.wbs_sel_i[0];
   assign flush_tx  = wr_ctrl && bus.wbs_dat_i[0];
   assign flush_rx  = wr_ctrl && bus.wbs_dat_i[1];
   assign clr_flags = wr_ctrl && bus.wbs_dat_i[2];

   // TX FIFO
   assign tx_full  = (tx_cnt_q == CW'(DEPTH));
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_push  = wr_tx && !tx_full;
   assign tx_pop   = !tx_empty && bus.m_axis_tready;

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
      if (!wbs_rst_i) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
      end else if (flush_tx) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
      end else begin
         if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
         if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
         else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge wbs_clk_i) begin
      if (tx_push) tx_mem[tx_wptr_q] <= bus.wbs_dat_i;
   end

   // RX FIFO; ready is held low until the first clock after reset release.
   assign rx_full  = (rx_cnt_q == CW'(DEPTH));
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_push  = bus.s_axis_tvalid && bus.s_axis_tready;
   assign rx_pop   = rd_rx && !rx_empty;

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
      if (!wbs_rst_i) rdy_q <= 1'b0;
      else            rdy_q <= 1'b1;
   end

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
      if (!wbs_rst_i) begin
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
      end else if (flush_rx) begin
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
      end else begin
         if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
         if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
         else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge wbs_clk_i) begin
      if (rx_push && !flush_rx) rx_mem[rx_wptr_q] <= bus.s_axis_tdata;
   end

   // Sticky flags; clear wins over a same-cycle set.
   always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
      if (!wbs_rst_i) begin
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         last_seen_q <= 1'b0;
      end else if (clr_flags) begin
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         last_seen_q <= 1'b0;
      end else begin
         if (wr_tx && tx_full)             ovf_q       <= 1'b1;
         if (rd_rx && rx_empty)            udf_q       <= 1'b1;
         if (rx_push && bus.s_axis_tlast)  last_seen_q <= 1'b1;
      end
   end

`ifdef STREAM_TLAST_EN
   logic [15:0] len_q, beat_q;

   assign tlast = !tx_empty && (len_q != 16'd0) && (beat_q == len_q - 16'd1);

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
      if (!wbs_rst_i) begin
         len_q  <= '0;
         beat_q <= '0;
      end else begin
         if (xfer && bus.wbs_we_i && (offset == 3'd4)) len_q <= bus.wbs_dat_i[15:0];
         if (flush_tx)    beat_q <= '0;
         else if (tx_pop) beat_q <= tlast ? 16'd0 : beat_q + 16'd1;
      end
   end
`else
   assign tlast = 1'b0;
`endif

   always_comb begin
      status        = '0;
      status[7:0]   = 8'(tx_cnt_q);
      status[15:8]  = 8'(rx_cnt_q);
      status[16]    = tx_full;
      status[17]    = tx_empty;
      status[18]    = rx_full;
      status[19]    = rx_empty;
      status[20]    = ovf_q;
      status[21]    = udf_q;
      status[22]    = last_seen_q;
   end

   always_comb begin
      rdata = '0;
      case (offset)
         3'd1:    rdata = rx_empty ? '0 : rx_mem[rx_rptr_q];
         3'd2:    rdata = DW'(status);
`ifdef STREAM_TLAST_EN
         3'd4:    rdata = DW'(len_q);
`endif
         default: rdata = '0;
      endcase
   end

   // Loaded only on the transfer edge, so it falls back to 0 on the ACK->IDLE edge.
   always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
      if (!wbs_rst_i) dat_q <= '0;
      else            dat_q <= (xfer && !bus.wbs_we_i) ? rdata : '0;
   end

   assign bus.wbs_ack_o     = (state_q == StAck);
   assign bus.wbs_dat_o     = bus.wbs_ack_o ? dat_q : '0;
   assign bus.m_axis_tvalid = !tx_empty;
   assign bus.m_axis_tdata  = tx_empty ? '0 : tx_mem[tx_rptr_q];
   assign bus.m_axis_tlast  = tlast;
   assign bus.s_axis_tready = rdy_q && !rx_full;
endmodule
